// File: rtl/conv_kxk_acc.sv
// conv_kxk_acc: LENxLEN window MAC accumulated over CH_NUM channel beats,
// followed by bias, rounding shift, optional ReLU and saturation.
module conv_kxk_acc #(
  parameter int WIDTH_D = 8,
  parameter int WIDTH_W = 20,
  parameter int LEN     = 7,
  parameter int CH_NUM  = 4,
  parameter int WIDTH_B = 32,
  parameter int SHIFT   = 8,
  parameter int WIDTH_O = 16
) (
  input  logic                       i_sclk,
  input  logic                       i_rst,
  input  logic                       i_vsync,
  input  logic                       i_hsync,
  input  logic                       i_reuse,
  input  logic                       i_valid,
  input  logic [WIDTH_D*LEN*LEN-1:0] i_tdata,
  input  logic [WIDTH_W*LEN*LEN-1:0] i_weight,
  input  logic [WIDTH_B-1:0]         i_bias,
  input  logic                       i_relu,
  output logic                       o_vsync,
  output logic                       o_hsync,
  output logic                       o_reuse,
  output logic                       o_valid,
  output logic [WIDTH_O-1:0]         o_tdata,
  output logic                       o_err
);

  localparam int N  = LEN * LEN;
  localparam int WP = WIDTH_D + WIDTH_W;
  localparam int WS = WP + $clog2(N) + 1;
  localparam int WA = WS + $clog2(CH_NUM) + 1;
  localparam int WT = (WA > WIDTH_B ? WA : WIDTH_B) + 2;
  localparam int CW = CH_NUM > 1 ? $clog2(CH_NUM) : 1;

  localparam logic signed [WT-1:0] RND  = WT'((64'd1 << SHIFT) >> 1);
  localparam logic signed [WT-1:0] OMAX =
    WT'((64'sd1 <<< (WIDTH_O - 1)) - 64'sd1);
  localparam logic signed [WT-1:0] OMIN = ~OMAX;

  logic signed [WP-1:0] prod [N];
  logic signed [WS-1:0] row  [LEN];
  logic signed [WS-1:0] row_d [LEN];
  logic signed [WS-1:0] col, col_d;
  logic signed [WA-1:0] acc;
  logic                 v0, v1, v2;
  logic [2:0]           sb0, sb1, sb2, sb_lat;
  logic [CW-1:0]        ch_cnt, cnt_eff;
  logic                 resync, first, last, done;
  logic signed [WT-1:0] tot, shd, clp;

  always_ff @(posedge i_sclk or posedge i_rst) begin
    if (i_rst) begin
      for (int c = 0; c < N; c++) prod[c] <= '0;
      v0  <= 1'b0;
      sb0 <= '0;
    end else begin
      for (int c = 0; c < N; c++)
        prod[c] <= WP'($signed(i_tdata[WIDTH_D*c +: WIDTH_D]))
                 * WP'($signed(i_weight[WIDTH_W*c +: WIDTH_W]));
      v0  <= i_valid;
      sb0 <= {i_vsync, i_hsync, i_reuse};
    end
  end

  always_comb begin
    for (int r = 0; r < LEN; r++) begin
      row_d[r] = '0;
      for (int k = 0; k < LEN; k++)
        row_d[r] = row_d[r] + WS'(prod[r*LEN+k]);
    end
    col_d = '0;
    for (int r = 0; r < LEN; r++) col_d = col_d + row[r];
  end

  always_ff @(posedge i_sclk or posedge i_rst) begin
    if (i_rst) begin
      for (int r = 0; r < LEN; r++) row[r] <= '0;
      col <= '0;
      v1  <= 1'b0;
      v2  <= 1'b0;
      sb1 <= '0;
      sb2 <= '0;
    end else begin
      for (int r = 0; r < LEN; r++) row[r] <= row_d[r];
      col <= v1 ? col_d : '0;
      v1  <= v0;
      v2  <= v1;
      sb1 <= sb0;
      sb2 <= sb1;
    end
  end

  // a vsync arriving mid-group restarts the group on this beat
  always_comb begin
    resync  = v2 && sb2[2] && (ch_cnt != '0);
    cnt_eff = resync ? '0 : ch_cnt;
    first   = (cnt_eff == '0);
    last    = (cnt_eff == CW'(CH_NUM - 1));
  end

  always_ff @(posedge i_sclk or posedge i_rst) begin
    if (i_rst) begin
      acc    <= '0;
      ch_cnt <= '0;
      sb_lat <= '0;
      done   <= 1'b0;
      o_err  <= 1'b0;
    end else begin
      o_err <= resync;
      done  <= v2 && last;
      if (v2) begin
        acc    <= first ? WA'(col) : acc + WA'(col);
        ch_cnt <= last ? '0 : cnt_eff + CW'(1);
        if (first) sb_lat <= sb2;
      end
    end
  end

  always_comb begin
    tot = WT'(acc) + WT'($signed(i_bias)) + RND;
    shd = tot >>> SHIFT;
    clp = shd;
    if (i_relu && shd < 0) clp = '0;
    if (clp > OMAX) clp = OMAX;
    else if (clp < OMIN) clp = OMIN;
  end

  always_ff @(posedge i_sclk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_tdata <= '0;
      o_vsync <= 1'b0;
      o_hsync <= 1'b0;
      o_reuse <= 1'b0;
    end else begin
      o_valid <= done;
      if (done) begin
        o_tdata <= clp[WIDTH_O-1:0];
        {o_vsync, o_hsync, o_reuse} <= sb_lat;
      end
    end
  end

endmodule

// File: doc/conv_kxk_acc.md
Name: conv_kxk_acc

Overview:
Parametrised successor to the fixed 7x7 window MAC. It multiplies one LENxLEN window by LENxLEN signed weights per valid beat and reduces the products through a pipeline: row sums, then column sum. It accumulates the results over CH_NUM consecutive input-channel beats, then adds a bias, rounds and shifts, applies optional ReLU and saturates to WIDTH_O. It sits between the window generator and the output feature-map writer and emits one result per output pixel instead of one per channel.

Parameters:
WIDTH_D, 8, signed pixel width
WIDTH_W, 20, signed weight width
LEN, 7, kernel side (LEN>=1); window = LEN*LEN taps
CH_NUM, 4, input-channel beats accumulated per output pixel (>=1)
WIDTH_B, 32, signed bias width
SHIFT, 8, arithmetic right shift applied after bias add (>=0)
WIDTH_O, 16, signed output width (saturated)

Ports:
i_sclk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_vsync  in  1  frame start, qualified by i_valid
i_hsync  in  1  line start, qualified by i_valid
i_reuse  in  1  sideband flag, passed through
i_valid  in  1  window beat valid
i_tdata  in  WIDTH_D*LEN*LEN  window; tap c at bits [WIDTH_D*(c+1)-1:WIDTH_D*c], row-major
i_weight  in  WIDTH_W*LEN*LEN  weights, same packing
i_bias  in  WIDTH_B  bias; quasi-static over a group
i_relu  in  1  1 = clamp negatives to 0; quasi-static
o_vsync  out  1  vsync of the group's first beat
o_hsync  out  1  hsync of the group's first beat
o_reuse  out  1  reuse of the group's first beat
o_valid  out  1  one-cycle result strobe
o_tdata  out  WIDTH_O  saturated result
o_err  out  1  one-cycle pulse: partial group discarded

Behaviour:
- Reset (async, i_rst=1): all outputs 0. All pipeline registers, valid/sideband delay lines, accumulator and channel counter are 0. Reset mid-group discards the partial group; no output is produced.
- Pipeline for a beat sampled at edge n:
  - edge n: LEN*LEN signed products.
  - edge n+1: LEN row sums.
  - edge n+2: column sum. Invalid beats force the column sum to 0.
  - edge n+3: accumulator update.
  - edge n+4: output register.
- Widths: product WIDTH_D+WIDTH_W. Column sum WIDTH_S = WIDTH_D+WIDTH_W+clog2(LEN*LEN)+1. Accumulator WIDTH_S+clog2(CH_NUM)+1. The accumulator can never wrap.
- Channel counter ch_cnt (0..CH_NUM-1) is tracked at the accumulator stage and advances only on valid beats. Idle cycles between beats are allowed; the accumulator holds during them.
- Group start: ch_cnt=0 loads acc <= column sum and latches vsync/hsync/reuse. Other valid beats do acc <= acc + column sum.
- Group end: a beat with ch_cnt=CH_NUM-1 wraps ch_cnt to 0. At the next edge the output stage registers:
  - o_valid=1.
  - o_tdata = sat(relu((acc + sext(i_bias) + round) >>> SHIFT)), where round = 2^(SHIFT-1) if SHIFT>0 else 0.
  - o_vsync/o_hsync/o_reuse from the latched values.
- Latency: last beat sampled at edge n, result registered at edge n+4.
- o_valid is 0 in all other cycles, and o_tdata holds its last value. Sideband outputs are only meaningful while o_valid=1.
- Saturation: results above 2^(WIDTH_O-1)-1 clip to that value; results below -2^(WIDTH_O-1) clip to that value. ReLU is applied before saturation.
- Resync: a valid beat with vsync=1 while ch_cnt!=0 at the accumulator stage does two things:
  - o_err pulses for one cycle, aligned with that beat's accumulator-stage edge.
  - The partial group is dropped and this beat becomes channel 0.
- CH_NUM=1: every valid beat produces a result. Resync can never fire.

Test Plan:
1. LEN=7, CH_NUM=4, SHIFT=0, bias 0, all data 1, weights 1, 4 back-to-back beats -> one o_valid 4 edges after beat 4, o_tdata=196; o_err never asserts.
2. Same stimulus with 2 idle cycles between each beat, bias=-100 -> single result 96; o_vsync/o_hsync equal the first beat's flags, not the last beat's.
3. SHIFT=2, CH_NUM=1, taps giving a sum of 6, then -6 -> outputs 2, then -1 (round-half-up arithmetic shift).
4. WIDTH_O=8, SHIFT=0, data 127, weights 1000 -> output 127. Negate the weights -> -128; with i_relu=1 -> 0.
5. CH_NUM=4, beats 1-2 sent, then beat 3 carries vsync=1, followed by 3 more beats of all-ones -> o_err pulses once; the only result is 196, with o_vsync=1.
6. Assert i_rst for 1 cycle after beat 3 of a group, then send 4 fresh beats -> all outputs 0 during reset; exactly one result, equal to the 4-beat sum of the fresh beats.
